// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM with a synchronous read port.
// Zero-wait pipelined by default, WAIT_STATES stretch OKAY data phases, and illegal accesses get a two-cycle ERROR.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;
  localparam logic [1:0] WS = 2'(WAIT_STATES);

  typedef enum logic [1:0] {S_OKAY, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                  state, state_nx;
  logic [1:0]              cnt;
  logic                    accept, a_err, wr_en;
  logic [ADDR_WIDTH-1:0]   a_off;
  logic [IDX_W-1:0]        a_idx;
  logic [3:0]              a_strb;
  logic                    dp_act, dp_write;
  logic [IDX_W-1:0]        dp_idx;
  logic [3:0]              dp_strb;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   rd_q, rd_nx;
  logic                    unused;

  assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address-phase decode: legality check and byte-lane strobes.
  assign accept = HSEL && HREADY && HTRANS[1];
  assign a_off  = HADDR - BASE_ADDR;
  assign a_idx  = a_off[IDX_W+1:2];

  always_comb begin
    a_err  = ({1'b0, a_off} >= MEM_BYTES);
    a_strb = 4'b1111;
    case (HSIZE)
      3'b000: a_strb = 4'b0001 << HADDR[1:0];
      3'b001: begin
        a_strb = HADDR[1] ? 4'b1100 : 4'b0011;
        if (HADDR[0]) a_err = 1'b1;
      end
      3'b010: if (HADDR[1:0] != 2'b00) a_err = 1'b1;
      default: a_err = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= S_OKAY;
      cnt      <= '0;
      dp_act   <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_WAIT) ? cnt - 2'd1 : WS;
      if (HREADY) begin
        dp_act   <= accept && !a_err;
        dp_write <= HWRITE;
        dp_idx   <= a_idx;
        dp_strb  <= a_strb;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_OKAY, S_ERR2: begin
        HRESP    = (state == S_ERR2);
        state_nx = S_OKAY;
        if (accept) state_nx = a_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_OKAY);
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 2'd1) state_nx = S_OKAY;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = S_ERR2;
      end
      default: state_nx = S_OKAY;
    endcase
  end

  // A write commits in the last (ready) cycle of its data phase.
  assign wr_en = dp_act && dp_write && (state == S_OKAY);

  // Read issued on the same edge as a commit to the same word sees the new bytes.
  always_comb begin
    rd_nx = mem[a_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_en && (dp_idx == a_idx) && dp_strb[b]) rd_nx[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (dp_strb[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
      if (accept && !HWRITE && !a_err) rd_q <= rd_nx;
    end
  end

  assign HRDATA = (dp_act && !dp_write && !HRESP) ? rd_q : '0;

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder that terminates the CPU-side master's bus traffic into an on-chip word-organised SRAM. It samples address phases qualified by HSEL/HREADY/HTRANS and performs byte, halfword or word accesses with configurable wait states. Illegal accesses get the two-cycle AHB ERROR response. It sits behind the interconnect as one slave port, opposite the core's AHB master.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, data bus width; only 32 supported
- MEM_DEPTH, 1024, number of 32-bit words; power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..3)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select from interconnect decoder
- HADDR  in  ADDR_WIDTH  byte address (address phase)
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  000 byte, 001 half, 010 word
- HBURST  in  3  ignored; every beat handled independently
- HPROT  in  4  ignored
- HMASTLOCK  in  1  ignored
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HREADY  in  1  bus-level ready (previous transfer complete)
- HREADYOUT  out  1  this slave's ready
- HRDATA  out  DATA_WIDTH  read data
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- Address phase accepted at a rising edge iff HSEL && HREADY && HTRANS[1]. IDLE/BUSY or unselected: no access, next data phase is zero-wait OKAY.
- On acceptance register: word index, byte offset HADDR[1:0], HSIZE, HWRITE, error flag.
- Error flag set if any: offset = HADDR-BASE_ADDR (unsigned) >= MEM_DEPTH*4; HSIZE > 010; HSIZE=001 with HADDR[0]=1; HSIZE=010 with HADDR[1:0]!=0. An errored transfer never touches SRAM.
- Byte strobes: byte -> 1<<HADDR[1:0]; half -> 0011 or 1100 by HADDR[1]; word -> 1111. Lane n = HWDATA[8n+7:8n]; little-endian.
- FSM states:
  - OKAY_IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, counter counts down from WAIT_STATES.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Accepted, no error: WAIT if WAIT_STATES>0, else stay OKAY_IDLE.
  - Accepted with error: ERR1.
  - WAIT: leave when counter reaches 1, to OKAY_IDLE. The final data-phase cycle has HREADYOUT=1.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> OKAY_IDLE. An address phase presented during ERR2 (HREADY=1) is accepted normally.
- Write commit: strobed bytes of HWDATA are written at the edge ending the write data phase (HREADYOUT=1 cycle).
- Read: SRAM read port is synchronous. Read issued at address acceptance; data valid from the first data-phase cycle and held until the phase completes.
- RAW forwarding: a read accepted on the same edge a write to the same word commits returns old word with the written strobed bytes merged in.
- HRDATA = read result only during a read data phase with HRESP=0; 0 at all other times.

## Timing
- Reset (HRESETn=0 at an edge): state OKAY_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, pending transfer discarded; any uncommitted write is dropped. SRAM contents are not cleared.
- Read latency: data on HRDATA in cycle after address acceptance + WAIT_STATES cycles.
- Back-to-back pipelined transfers at WAIT_STATES=0 sustain one transfer per cycle, including write->read same address.
- Error response is exactly 2 data-phase cycles regardless of WAIT_STATES.
- HREADYOUT low only in WAIT and ERR1. HSEL deasserted during a data phase does not abort it.

## Test plan
- Reset: hold HRESETn=0 two cycles with HTRANS=10 -> HREADYOUT=1, HRESP=0, HRDATA=0, no write occurs.
- Word write/read, WAIT_STATES=0:
  - NONSEQ write 0x10, HSIZE=010, HWDATA=0xDEADBEEF; then NONSEQ read 0x10 in the write's data phase.
  - Read data phase HRDATA=0xDEADBEEF (forwarded), HREADYOUT=1 throughout.
- Sub-word:
  - Write byte 0x13 = 0xAA over word 0x11223344 -> read 0x10 gives 0xAA223344.
  - Half write 0x12 = 0x5566 -> read gives 0x55663344.
- Wait states, WAIT_STATES=2: read 0x10 -> HREADYOUT low 2 cycles, then high with valid HRDATA; next address phase is accepted only at that edge.
- Errors:
  - Read at BASE_ADDR+MEM_DEPTH*4 -> HREADYOUT/HRESP 0/1 then 1/1, HRDATA=0.
  - Word write to 0x02 -> same two-cycle ERROR; word 0x00 unchanged.
- IDLE/BUSY and HSEL=0 cycles interleaved with valid transfers -> no SRAM access, HREADYOUT=1, HRESP=0.
- Reset asserted during WAIT of a write -> write not committed, HREADYOUT=1 next cycle.
